axi_stream_header_arbiter: RTL and testbench
============================================

Name: axi_stream_header_arbiter

Overview:
- Schedules header insertion for the AXI-Stream header-insert datapath.
- Arbitrates among NUM_REQ header requesters using round-robin.
- Latches the winning header and presents it on the insert port (valid_insert/data_insert/keep_insert/byte_insert_cnt).
- Monitors the output stream and holds off the next header until the current packet's last beat has been accepted downstream, so only one header is in flight per packet.

Parameters:
- DATA_WD, 32, stream/header data width in bits
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width minus 1
- NUM_REQ, 4, number of header requesters (2..16)
- REQ_ID_WD, $clog2(NUM_REQ), grant index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester header valid
- req_ready  out  NUM_REQ  one-hot pulse: header accepted
- req_data  in  NUM_REQ*DATA_WD  requester r header in slice [r*DATA_WD +: DATA_WD]
- req_cnt  in  NUM_REQ*(BYTE_CNT_WD+1)  requester r header byte count
- valid_insert  out  1  header valid to insert block
- data_insert  out  DATA_WD  latched header
- keep_insert  out  DATA_BYTE_WD  right-aligned keep derived from count
- byte_insert_cnt  out  BYTE_CNT_WD+1  latched header byte count
- ready_insert  in  1  insert block accepts header
- mon_valid_out, mon_ready_out, mon_last_out  in  1 each  tap of the insert block output handshake
- grant_id  out  REQ_ID_WD  index of current or last granted requester
- busy  out  1  high in ISSUE or BUSY
- pkt_cnt  out  16  completed packets, wraps
- err_bad_cnt  out  8  rejected headers, saturates at 255

Behaviour:
- Reset values:
  - req_ready=0, valid_insert=0, data_insert=0, keep_insert=0, byte_insert_cnt=0
  - grant_id=0, busy=0, pkt_cnt=0, err_bad_cnt=0
  - RR pointer=0, state=IDLE
- All outputs are registered.
- State machine IDLE/ISSUE/BUSY:
  - IDLE: if any req_valid, select the winner as the first asserted index searching from ptr upward with wrap.
    - Next edge: req_ready[winner]=1 for exactly one cycle; grant_id=winner; ptr=winner+1 mod NUM_REQ.
    - Valid count (1..DATA_BYTE_WD): latch data/cnt; keep_insert = low cnt bits set, e.g. cnt=3, DATA_BYTE_WD=4 gives 4'b0111. valid_insert=1, go to ISSUE.
    - Invalid count (0 or >DATA_BYTE_WD): header is consumed and dropped; err_bad_cnt++ (saturating); stay IDLE.
  - ISSUE: hold valid_insert and all insert fields stable until ready_insert=1.
    - At the handshake edge: valid_insert=0, go to BUSY.
    - A single-cycle handshake is legal, giving 1 cycle of ISSUE.
  - BUSY: wait for mon_valid_out && mon_ready_out && mon_last_out; then pkt_cnt++ and go to IDLE.
    - A last beat seen in IDLE or ISSUE is ignored (no count).
- Latency: req_valid to valid_insert = 1 cycle.
- Minimum gap from last-beat acceptance to the next req_ready = 1 cycle (IDLE evaluates on the following cycle).
- Requests arriving while busy are held off: req_ready=0. Requesters must hold req_valid and data stable until req_ready.
- A requester deasserting req_valid before being granted is legal; it is simply not selected.
- req_ready is never asserted to more than one requester in the same cycle.
- rst asserted in any state returns all state at the next edge. An in-flight header is abandoned: valid_insert drops and no req_ready is generated.

Optional Feature:
- Macro: HDR_ARB_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 1024) and output timeout_err (1 bit, sticky, cleared only by rst).
  - A 16-bit counter counts cycles spent in ISSUE+BUSY and is cleared on entry from IDLE.
  - On reaching TIMEOUT: go to IDLE, drop valid_insert, set timeout_err, do not increment pkt_cnt.
- When undefined: no counter, no port; the FSM waits indefinitely.

Test Plan:
- Single request: req_valid[2]=1, cnt=3, data=32'hAABBCCDD; ready_insert=1 at cycle 2 → req_ready[2] pulse at cycle 1; valid_insert=1 with keep_insert=4'b0111 at cycle 1; valid_insert=0 after the handshake; busy stays 1 until the last beat, then pkt_cnt=1.
- Round-robin fairness: all 4 req_valid held, each packet 2 beats → grant order 0,1,2,3,0; no requester granted twice before the others.
- Backpressure: ready_insert=0 for 10 cycles → valid_insert and data_insert stable for 10 cycles, one handshake only, no second req_ready.
- Bad count: req_cnt=0 and then 5 on requester 1 → req_ready[1] pulses each time, valid_insert stays 0, err_bad_cnt=2; a following valid request proceeds normally.
- Back-to-back and reset: new req_valid in the same cycle as the last-beat handshake → next req_ready exactly 1 cycle after returning to IDLE. rst during BUSY → all outputs at reset values next cycle, pkt_cnt=0.
- With HDR_ARB_TIMEOUT_EN, TIMEOUT=16: no last beat → timeout_err=1 after 16 cycles, state IDLE, pkt_cnt unchanged.

Source files
------------

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin header arbiter for the AXI-Stream header-insert datapath; one header in flight per packet.
// Optional HDR_ARB_TIMEOUT_EN adds an ISSUE+BUSY watchdog with sticky timeout_err.
//   state | meaning
//   IDLE  | arbitrate among req_valid from the round-robin pointer
//   ISSUE | header presented on the insert port, waiting for ready_insert
//   BUSY  | header accepted, waiting for the packet's last beat downstream
module axi_stream_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ      = 4,
    parameter int REQ_ID_WD    = $clog2(NUM_REQ)
`ifdef HDR_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 1024
`endif
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DATA_WD-1:0]         req_data,
    input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0] req_cnt,
    output logic                               valid_insert,
    output logic [DATA_WD-1:0]                 data_insert,
    output logic [DATA_BYTE_WD-1:0]            keep_insert,
    output logic [BYTE_CNT_WD:0]               byte_insert_cnt,
    input  logic                               ready_insert,
    input  logic                               mon_valid_out,
    input  logic                               mon_ready_out,
    input  logic                               mon_last_out,
    output logic [REQ_ID_WD-1:0]               grant_id,
    output logic                               busy,
    output logic [15:0]                        pkt_cnt,
    output logic [7:0]                         err_bad_cnt
`ifdef HDR_ARB_TIMEOUT_EN
    ,
    output logic                               timeout_err
`endif
);

    localparam int CNT_WD = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

    state_t                 state_q, state_d;
    logic [REQ_ID_WD-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     req_ready_d;
    logic                   valid_insert_d;
    logic [DATA_WD-1:0]     data_insert_d;
    logic [DATA_BYTE_WD-1:0] keep_insert_d;
    logic [CNT_WD-1:0]      byte_insert_cnt_d;
    logic [REQ_ID_WD-1:0]   grant_id_d;
    logic                   busy_d;
    logic [15:0]            pkt_cnt_d;
    logic [7:0]             err_bad_cnt_d;

    logic                   win_found;
    logic [REQ_ID_WD-1:0]   win_id;
    logic [CNT_WD-1:0]      win_cnt;
    logic [DATA_WD-1:0]     win_data;
    logic                   cnt_ok;
    logic [DATA_BYTE_WD-1:0] keep_calc;
    logic                   last_acc;

`ifdef HDR_ARB_TIMEOUT_EN
    logic [15:0]            tmo_q, tmo_d;
    logic                   timeout_err_d;
`endif

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = REQ_ID_WD'(idx);
            end
        end
    end

    assign win_cnt  = req_cnt[win_id*CNT_WD +: CNT_WD];
    assign win_data = req_data[win_id*DATA_WD +: DATA_WD];
    assign cnt_ok   = (win_cnt != '0) && (int'(win_cnt) <= DATA_BYTE_WD);
    assign last_acc = mon_valid_out && mon_ready_out && mon_last_out;

    always_comb begin
        keep_calc = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) keep_calc[i] = (i < int'(win_cnt));
    end

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        req_ready_d       = '0;
        valid_insert_d    = valid_insert;
        data_insert_d     = data_insert;
        keep_insert_d     = keep_insert;
        byte_insert_cnt_d = byte_insert_cnt;
        grant_id_d        = grant_id;
        busy_d            = busy;
        pkt_cnt_d         = pkt_cnt;
        err_bad_cnt_d     = err_bad_cnt;
`ifdef HDR_ARB_TIMEOUT_EN
        tmo_d             = tmo_q;
        timeout_err_d     = timeout_err;
`endif
        case (state_q)
            S_IDLE: begin
                // Skip the cycle a req_ready pulse is out: the granted requester still shows valid then.
                if (win_found && (req_ready == '0)) begin
                    req_ready_d[win_id] = 1'b1;
                    grant_id_d          = win_id;
                    ptr_d = (win_id == REQ_ID_WD'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    if (cnt_ok) begin
                        data_insert_d     = win_data;
                        byte_insert_cnt_d = win_cnt;
                        keep_insert_d     = keep_calc;
                        valid_insert_d    = 1'b1;
                        busy_d            = 1'b1;
                        state_d           = S_ISSUE;
`ifdef HDR_ARB_TIMEOUT_EN
                        tmo_d             = '0;
`endif
                    end else if (err_bad_cnt != 8'hFF) begin
                        err_bad_cnt_d = err_bad_cnt + 8'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (ready_insert) begin
                    valid_insert_d = 1'b0;
                    state_d        = S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_acc) begin
                    pkt_cnt_d = pkt_cnt + 16'd1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef HDR_ARB_TIMEOUT_EN
        if ((state_q == S_ISSUE) || (state_q == S_BUSY && !last_acc)) begin
            tmo_d = tmo_q + 16'd1;
            if (tmo_q == 16'(TIMEOUT - 1)) begin
                state_d        = S_IDLE;
                valid_insert_d = 1'b0;
                busy_d         = 1'b0;
                timeout_err_d  = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            req_ready       <= '0;
            valid_insert    <= 1'b0;
            data_insert     <= '0;
            keep_insert     <= '0;
            byte_insert_cnt <= '0;
            grant_id        <= '0;
            busy            <= 1'b0;
            pkt_cnt         <= '0;
            err_bad_cnt     <= '0;
`ifdef HDR_ARB_TIMEOUT_EN
            tmo_q           <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            req_ready       <= req_ready_d;
            valid_insert    <= valid_insert_d;
            data_insert     <= data_insert_d;
            keep_insert     <= keep_insert_d;
            byte_insert_cnt <= byte_insert_cnt_d;
            grant_id        <= grant_id_d;
            busy            <= busy_d;
            pkt_cnt         <= pkt_cnt_d;
            err_bad_cnt     <= err_bad_cnt_d;
`ifdef HDR_ARB_TIMEOUT_EN
            tmo_q           <= tmo_d;
            timeout_err     <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Directed bench for axi_stream_header_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_axi_stream_header_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [127:0] req_data;
    logic [11:0] req_cnt;
    logic [2:0]  cnt_v = '0;
    logic        valid_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic [2:0]  byte_insert_cnt;
    logic        ready_insert = 1'b0;
    logic        mon_valid_out = 1'b0, mon_ready_out = 1'b0, mon_last_out = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_bad_cnt;
`ifdef HDR_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    logic [31:0] dtab [4] = '{32'h10203040, 32'h55667788, 32'hAABBCCDD, 32'hDEADBEEF};
    assign req_data = {dtab[3], dtab[2], dtab[1], dtab[0]};
    assign req_cnt  = {4{cnt_v}};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef HDR_ARB_TIMEOUT_EN
    axi_stream_header_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_cnt(req_cnt),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .mon_valid_out(mon_valid_out), .mon_ready_out(mon_ready_out), .mon_last_out(mon_last_out),
        .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt), .err_bad_cnt(err_bad_cnt),
        .timeout_err(timeout_err)
    );
`else
    axi_stream_header_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_cnt(req_cnt),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .mon_valid_out(mon_valid_out), .mon_ready_out(mon_ready_out), .mon_last_out(mon_last_out),
        .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt), .err_bad_cnt(err_bad_cnt)
    );
`endif

    typedef struct {
        logic [3:0]  rv;
        logic [2:0]  cnt;
        logic        ri;
        logic [2:0]  mon;
        logic [3:0]  rr;
        logic        vi;
        logic [3:0]  keep;
        logic [2:0]  bcnt;
        logic [1:0]  gid;
        logic        bsy;
        logic [15:0] pkt;
        logic [7:0]  err;
    } vec_t;

    vec_t vt [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_mon(input logic [2:0] m);
        {mon_valid_out, mon_ready_out, mon_last_out} = m;
    endtask

    task automatic wait_grant(input string nm, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, " grant timeout"}, 32'(req_ready), 32'hF);
    endtask

    initial begin
        bit ok;
        int n;
        logic [15:0] pkt_base;
        //         rv       cnt ri mon      rr       vi keep     bcnt gid bsy pkt err
        vt[0]  = '{4'b0100, 3, 0, 3'b000, 4'b0100, 1, 4'b0111, 3, 2, 1, 0, 0};
        vt[1]  = '{4'b0100, 3, 1, 3'b000, 4'b0000, 0, 4'b0111, 3, 2, 1, 0, 0};
        vt[2]  = '{4'b0000, 3, 0, 3'b110, 4'b0000, 0, 4'b0111, 3, 2, 1, 0, 0};
        vt[3]  = '{4'b0000, 3, 0, 3'b101, 4'b0000, 0, 4'b0111, 3, 2, 1, 0, 0};
        vt[4]  = '{4'b0000, 3, 0, 3'b111, 4'b0000, 0, 4'b0111, 3, 2, 0, 1, 0};
        vt[5]  = '{4'b0000, 3, 0, 3'b000, 4'b0000, 0, 4'b0111, 3, 2, 0, 1, 0};
        vt[6]  = '{4'b0010, 0, 0, 3'b000, 4'b0010, 0, 4'b0111, 3, 1, 0, 1, 1};
        vt[7]  = '{4'b0010, 0, 0, 3'b000, 4'b0000, 0, 4'b0111, 3, 1, 0, 1, 1};
        vt[8]  = '{4'b0010, 5, 0, 3'b000, 4'b0010, 0, 4'b0111, 3, 1, 0, 1, 2};
        vt[9]  = '{4'b0000, 5, 0, 3'b111, 4'b0000, 0, 4'b0111, 3, 1, 0, 1, 2};
        vt[10] = '{4'b0010, 4, 0, 3'b000, 4'b0010, 1, 4'b1111, 4, 1, 1, 1, 2};
        vt[11] = '{4'b0010, 4, 0, 3'b000, 4'b0000, 1, 4'b1111, 4, 1, 1, 1, 2};
        vt[12] = '{4'b0000, 4, 1, 3'b111, 4'b0000, 0, 4'b1111, 4, 1, 1, 1, 2};
        vt[13] = '{4'b1111, 4, 0, 3'b000, 4'b0000, 0, 4'b1111, 4, 1, 1, 1, 2};
        vt[14] = '{4'b1111, 4, 0, 3'b111, 4'b0000, 0, 4'b1111, 4, 1, 0, 2, 2};
        vt[15] = '{4'b1111, 4, 0, 3'b000, 4'b0100, 1, 4'b1111, 4, 2, 1, 2, 2};

        // reset values
        rst = 1'b1;
        step();
        step();
        chk("rst req_ready", 32'(req_ready), 0);
        chk("rst valid_insert", 32'(valid_insert), 0);
        chk("rst data_insert", data_insert, 0);
        chk("rst keep/cnt/gid/busy", {keep_insert, byte_insert_cnt, grant_id, busy}, 0);
        chk("rst pkt/err", {pkt_cnt, err_bad_cnt}, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req_valid    = vt[i].rv;
            cnt_v        = vt[i].cnt;
            ready_insert = vt[i].ri;
            set_mon(vt[i].mon);
            step();
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vt[i].rr));
            chk($sformatf("row%0d valid_insert", i), 32'(valid_insert), 32'(vt[i].vi));
            chk($sformatf("row%0d keep", i), 32'(keep_insert), 32'(vt[i].keep));
            chk($sformatf("row%0d byte_cnt", i), 32'(byte_insert_cnt), 32'(vt[i].bcnt));
            chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(vt[i].gid));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vt[i].bsy));
            chk($sformatf("row%0d pkt_cnt", i), 32'(pkt_cnt), 32'(vt[i].pkt));
            chk($sformatf("row%0d err_bad_cnt", i), 32'(err_bad_cnt), 32'(vt[i].err));
            if (vt[i].vi) chk($sformatf("row%0d data", i), data_insert, dtab[vt[i].gid]);
        end

        // reset while BUSY
        req_valid = '0;
        ready_insert = 1'b1;
        set_mon(3'b000);
        step();
        chk("pre-reset busy", {31'd0, busy}, 1);
        ready_insert = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("busy-rst valid/busy/ready", {27'd0, valid_insert, busy, req_ready}, 0);
        chk("busy-rst data", data_insert, 0);
        chk("busy-rst keep/cnt/gid", {keep_insert, byte_insert_cnt, grant_id}, 0);
        chk("busy-rst pkt/err", {pkt_cnt, err_bad_cnt}, 0);

        // round-robin with all requesters held, 2-beat packets
        req_valid = 4'b1111;
        cnt_v = 3'd4;
        ready_insert = 1'b1;
        for (int p = 0; p < 5; p++) begin
            wait_grant($sformatf("rr%0d", p), ok);
            if (!ok) break;
            chk($sformatf("rr%0d one-hot", p), 32'(req_ready), 32'(4'b0001 << (p % 4)));
            chk($sformatf("rr%0d grant_id", p), 32'(grant_id), 32'(p % 4));
            chk($sformatf("rr%0d data", p), data_insert, dtab[p % 4]);
            step();
            chk($sformatf("rr%0d issued", p), {30'd0, valid_insert, busy}, 1);
            set_mon(3'b110);
            step();
            set_mon(3'b111);
            step();
            set_mon(3'b000);
            chk($sformatf("rr%0d pkt_cnt", p), 32'(pkt_cnt), 32'(p + 1));
        end

        // backpressure: header held for 10 cycles, one handshake only
        req_valid = 4'b1000;
        cnt_v = 3'd2;
        ready_insert = 1'b0;
        wait_grant("bp", ok);
        chk("bp grant_id", 32'(grant_id), 3);
        chk("bp keep", 32'(keep_insert), 32'h3);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("bp hold%0d", c), {data_insert}, dtab[3]);
            chk($sformatf("bp hold%0d vi/rr", c), {27'd0, valid_insert, req_ready}, 32'h10);
        end
        ready_insert = 1'b1;
        step();
        chk("bp handshake", {27'd0, valid_insert, req_ready}, 0);
        n = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (req_ready != '0 || valid_insert) n++;
        end
        chk("bp no second grant", 32'(n), 0);
        req_valid = '0;
        set_mon(3'b111);
        step();
        set_mon(3'b000);
        chk("bp pkt_cnt", 32'(pkt_cnt), 6);

`ifdef HDR_ARB_TIMEOUT_EN
        // no last beat: watchdog returns to IDLE after 16 cycles
        pkt_base = pkt_cnt;
        req_valid = 4'b0001;
        ready_insert = 1'b1;
        wait_grant("tmo", ok);
        req_valid = '0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            n++;
            step();
        end
        chk("tmo busy cycles", 32'(n), 16);
        chk("tmo timeout_err", {31'd0, timeout_err}, 1);
        chk("tmo pkt_cnt", 32'(pkt_cnt), 32'(pkt_base));
`else
        pkt_base = pkt_cnt;
        chk("final pkt_cnt", 32'(pkt_base), 6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
